// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Opcode map of the 16-bit ISA, register-index width, pending-counter reload
// value and a helper that turns a register index into a one-hot mask with
// register 0 excluded.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W    = 2;
  localparam int unsigned NUM_REGS = 1 << REG_W;
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned CNT_W    = 16;

  // Cycles a freshly issued producer blocks its readers.
  localparam logic [PEND_W-1:0] PEND_INIT = 2'd3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_ADDI = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11
  } opcode_e;

  typedef logic [NUM_REGS-1:0] reg_mask_t;

  // Register 0 is hard-wired, so it never appears in a hazard mask.
  function automatic reg_mask_t reg_onehot(input logic [REG_W-1:0] idx);
    reg_mask_t m;
    m = '0;
    if (idx != '0) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
// hazard_decode: purely combinational register-usage decoder.
// Ports:
//   i_ir      - instruction word
//   o_rd_mask - one-hot set of registers the instruction reads (bit 0 never set)
//   o_wr_mask - one-hot set of registers the instruction writes (bit 0 never set)
//   o_valid   - opcode is one of the defined register-using instructions
module hazard_decode (
  input  logic [15:0] i_ir,
  output logic [3:0]  o_rd_mask,
  output logic [3:0]  o_wr_mask,
  output logic        o_valid
);
  import pipeline_hazard_ctrl_pkg::*;

  reg_mask_t w_rs;
  reg_mask_t w_rt;
  reg_mask_t w_rd;
  logic      w_unused_imm;

  assign w_rs = reg_onehot(i_ir[11:10]);
  assign w_rt = reg_onehot(i_ir[9:8]);
  assign w_rd = reg_onehot(i_ir[7:6]);

  // Low bits are immediate/function fields with no register meaning.
  assign w_unused_imm = ^i_ir[5:0];

  always_comb begin
    o_rd_mask = '0;
    o_wr_mask = '0;
    o_valid   = 1'b1;
    case (i_ir[15:12])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL: begin
        o_rd_mask = w_rs | w_rt;
        o_wr_mask = w_rd;
      end
      OP_ADDI, OP_LW: begin
        o_rd_mask = w_rs;
        o_wr_mask = w_rt;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        o_rd_mask = w_rs | w_rt;
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW-hazard stall and branch-flush controller for a
// 5-stage pipeline whose registers update on the falling clock edge.
// Ports:
//   clock        - single clock, state changes on the falling edge
//   reset_n      - synchronous active-low reset
//   id_ir        - instruction in IFID
//   id_valid     - id_ir holds a real instruction
//   branch_taken - branch in EXMEM resolves taken this cycle
//   stall        - hold PC/IFID, bubble into IDEX
//   flush_ifid   - zero IFID on the next edge
//   flush_idex   - zero IDEX control on the next edge
//   flush_ex     - zero EXMEM control on the next edge
//   issue        - ID instruction advances to IDEX on this edge
//   stall_cycles - saturating count of stalled cycles
//   flush_events - saturating count of taken-branch cycles
module pipeline_hazard_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] id_ir,
  input  logic        id_valid,
  input  logic        branch_taken,
  output logic        stall,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_ex,
  output logic        issue,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);
  import pipeline_hazard_ctrl_pkg::*;

  reg_mask_t                          w_dec_rd;
  reg_mask_t                          w_dec_wr;
  logic                               w_dec_valid;
  logic                               w_id_live;
  reg_mask_t                          w_src_mask;
  reg_mask_t                          w_dst_mask;
  logic                               w_src_busy;
  logic                               w_stall;
  logic                               w_issue;
  logic                               w_flush;

  logic [NUM_REGS-1:0][PEND_W-1:0]    r_pend;
  logic [CNT_W-1:0]                   r_stall_cycles;
  logic [CNT_W-1:0]                   r_flush_events;

  hazard_decode u_decode (
    .i_ir      (id_ir),
    .o_rd_mask (w_dec_rd),
    .o_wr_mask (w_dec_wr),
    .o_valid   (w_dec_valid)
  );

  assign w_id_live  = id_valid & w_dec_valid;
  assign w_src_mask = w_dec_rd & {NUM_REGS{w_id_live}};
  assign w_dst_mask = w_dec_wr & {NUM_REGS{w_id_live}};

  always_comb begin
    w_src_busy = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_src_mask[i] && (r_pend[i] != '0)) w_src_busy = 1'b1;
    end
  end

  // reset_n gates every control output so the pipeline sees no stall/flush/issue
  // while held in reset.
  assign w_flush = reset_n & branch_taken;
  assign w_stall = reset_n & id_valid & ~branch_taken & w_src_busy;
  assign w_issue = reset_n & id_valid & ~branch_taken & ~w_stall;

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      r_pend         <= '0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_pend[0] <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        // A count of PEND_INIT means the producer issued last cycle and now
        // sits in IDEX, which the taken branch is squashing.
        if (branch_taken && (r_pend[i] == PEND_INIT)) begin
          r_pend[i] <= '0;
        end else if (w_issue && w_dst_mask[i]) begin
          r_pend[i] <= PEND_INIT;
        end else if (r_pend[i] != '0) begin
          r_pend[i] <= r_pend[i] - 2'd1;
        end
      end
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (branch_taken && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

  assign stall        = w_stall;
  assign issue        = w_issue;
  assign flush_ifid   = w_flush;
  assign flush_idex   = w_flush;
  assign flush_ex     = w_flush;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule
